// File: rtl/line_window_gen.sv
// line_window_gen: builds a vertical 5-pixel column (rows y..y-4) from a raster
// pixel stream, using five rotating line buffers with registered reads.
// Optional feature macro: LWG_BORDER_REPLICATE_EN -- output during the first
// four lines of a frame, replicating line 0 upward into the missing rows.
module line_window_gen #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2000,
    parameter int ADDR_W = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_sol,
    input  logic                 s_sof,
    output logic                 m_valid,
    output logic [5*WIDTH-1:0]   m_col,
    output logic [ADDR_W-1:0]    m_x,
    output logic                 m_sol,
    output logic                 ovf
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  x_q, x_d;
    logic [2:0]         wsel_q, wsel_d;
    logic [1:0]         lcnt_q, lcnt_d;
    logic               ovf_q, ovf_d;
    logic               m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]  m_x_q, m_x_d;
    logic               m_sol_q, m_sol_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic               sol;
    logic               drop;
    logic               acc;
    logic [ADDR_W-1:0]  col;
    logic [4:0][WIDTH-1:0] rd_all;

    // Next-state: pixel acceptance, column/line bookkeeping, buffer rotation
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        wsel_d    = wsel_q;
        lcnt_d    = lcnt_q;
        ovf_d     = ovf_q;
        m_x_d     = m_x_q;
        data_d    = data_q;
        m_valid_d = 1'b0;
        m_sol_d   = 1'b0;

        sol  = s_sol | s_sof;
        col  = sol ? '0 : x_q + ADDR_W'(1);
        drop = s_valid && (state_q != IDLE) && !sol && (x_q == ADDR_W'(DEPTH - 1));
        acc  = s_valid && !drop && ((state_q != IDLE) || s_sof);

        if (drop) begin
            ovf_d = 1'b1;
        end

        if (acc) begin
            x_d     = col;
            m_x_d   = col;
            m_sol_d = sol;
            data_d  = s_data;
            if (s_sof) begin
                wsel_d  = '0;
                lcnt_d  = '0;
                state_d = FILL;
            end else if (sol) begin
                wsel_d = (wsel_q == 3'd4) ? '0 : wsel_q + 3'd1;
                if (state_q == FILL) begin
                    if (lcnt_q == 2'd3) begin
                        state_d = RUN;
                    end else begin
                        lcnt_d = lcnt_q + 2'd1;
                    end
                end
            end
`ifdef LWG_BORDER_REPLICATE_EN
            m_valid_d = (state_d == RUN) || (state_d == FILL);
`else
            m_valid_d = (state_d == RUN);
`endif
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            wsel_q    <= '0;
            lcnt_q    <= '0;
            ovf_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_x_q     <= '0;
            m_sol_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            wsel_q    <= wsel_d;
            lcnt_q    <= lcnt_d;
            ovf_q     <= ovf_d;
            m_valid_q <= m_valid_d;
            m_x_q     <= m_x_d;
            m_sol_q   <= m_sol_d;
            data_q    <= data_d;
        end
    end

    for (genvar b = 0; b < 5; b++) begin : g_buf
        logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
        logic [WIDTH-1:0] rd_q;

        // Line buffer write port: only the buffer currently selected by wsel
        always_ff @(posedge clk) begin
            if (acc && (wsel_d == 3'(b))) begin
                mem[col] <= s_data;
            end
        end

        // Registered read at the incoming column, held across stalls
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (acc) begin
                rd_q <= mem[col];
            end
        end

        assign rd_all[b] = rd_q;
    end

    // Column assembly: age k comes from buffer (wsel-k) mod 5; wsel_q is the
    // buffer the sampled pixel was written to, so it aligns with the read data
    always_comb begin
        logic [4:0][WIDTH-1:0] rows;
        logic [2:0]            age;
        rows[0] = data_q;
        for (int unsigned k = 1; k < 5; k++) begin
            rows[3'(k)] = rd_all[3'((32'(wsel_q) + 32'd5 - k) % 32'd5)];
        end
        m_col = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            age = 3'(k);
`ifdef LWG_BORDER_REPLICATE_EN
            if (state_q == FILL && age > {1'b0, lcnt_q}) begin
                age = {1'b0, lcnt_q};
            end
`endif
            m_col[k*WIDTH +: WIDTH] = rows[age];
        end
    end

    assign m_valid = m_valid_q;
    assign m_x     = m_x_q;
    assign m_sol   = m_sol_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: frame-level reference model (pixels stored per
// line number) compared every cycle, plus directed boundary scenarios.
module tb_line_window_gen;

    localparam int W  = 8;
    localparam int D  = 40;
    localparam int AW = 6;
`ifdef LWG_BORDER_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    typedef struct packed {
        bit         v;
        bit         sol;
        bit         sof;
        logic [W-1:0] d;
    } px_t;

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic [W-1:0]    s_data;
    logic            s_sol;
    logic            s_sof;
    logic            m_valid;
    logic [5*W-1:0]  m_col;
    logic [AW-1:0]   m_x;
    logic            m_sol;
    logic            ovf;

    int checks = 0;
    int errors = 0;

    px_t stim[$];
    px_t stim2[$];

    // reference model state
    logic [W-1:0]   fr [16][D];
    bit             md_act;
    int             md_line;
    int             md_x;
    bit             md_ovf;
    bit             exp_valid;
    logic [5*W-1:0] exp_col;
    int             exp_x;
    bit             exp_sol;

    line_window_gen #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
        .s_sol(s_sol), .s_sof(s_sof), .m_valid(m_valid), .m_col(m_col),
        .m_x(m_x), .m_sol(m_sol), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input px_t p);
        bit acc;
        int ln;
        exp_valid = 1'b0;
        exp_sol   = 1'b0;
        if (p.v) begin
            acc = 1'b0;
            if (p.sof) begin
                md_act = 1'b1; md_line = 0; md_x = 0; acc = 1'b1;
            end else if (md_act) begin
                if (p.sol) begin
                    md_line++; md_x = 0; acc = 1'b1;
                end else if (md_x == D - 1) begin
                    md_ovf = 1'b1;
                end else begin
                    md_x++; acc = 1'b1;
                end
            end
            if (acc) begin
                fr[md_line % 16][md_x] = p.d;
                exp_valid = REPL || (md_line >= 4);
                for (int k = 0; k < 5; k++) begin
                    ln = md_line - k;
                    if (ln < 0) ln = 0;
                    exp_col[k*W +: W] = fr[ln % 16][md_x];
                end
                exp_x   = md_x;
                exp_sol = p.sol || p.sof;
            end
        end
    endfunction

    task automatic step(input px_t p);
        s_valid = p.v; s_sol = p.sol; s_sof = p.sof; s_data = p.d;
        model(p);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_line(input int line, input int len, input int gap,
                            input bit sof, input bit rnd);
        px_t p;
        px_t idle;
        idle = '0;
        for (int x = 0; x < len; x++) begin
            if ($urandom_range(99) < gap) stim.push_back(idle);
            p.v   = 1'b1;
            p.sol = (x == 0);
            p.sof = (x == 0) && sof;
            p.d   = rnd ? W'($urandom) : W'(16 * line + x);
            stim.push_back(p);
        end
    endtask

    task automatic test_reset();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_col !== '0) begin errors++; $display("FAIL reset_m_col got %h want 0", m_col); end
        checks++; if (m_x !== '0) begin errors++; $display("FAIL reset_m_x got %0d want 0", m_x); end
        checks++; if (m_sol !== 1'b0) begin errors++; $display("FAIL reset_m_sol got %b want 0", m_sol); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    endtask

    task automatic test_frame();
        int ln = -1;
        int x = 0;
        stim.delete();
        for (int l = 0; l < 6; l++) add_line(l, 8, 0, l == 0, 0);
        foreach (stim[i]) begin
            if (stim[i].v) begin
                if (stim[i].sol) begin ln++; x = 0; end else x++;
            end
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL frame_valid idx %0d got %b want %b", i, m_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (m_col !== exp_col || m_x !== AW'(exp_x) || m_sol !== exp_sol)
                begin errors++; $display("FAIL frame_col idx %0d got %h/%0d/%b want %h/%0d/%b", i, m_col, m_x, m_sol, exp_col, exp_x, exp_sol); end
            end
            if (!REPL && ln == 4 && x == 0) begin
                checks++;
                if (m_valid !== 1'b1 || m_col !== 40'h0010203040)
                begin errors++; $display("FAIL first_window got %b %h want 1 0010203040", m_valid, m_col); end
            end
            if (REPL && ln == 1 && x == 3) begin
                checks++;
                if (m_valid !== 1'b1 || m_col !== 40'h0303030313)
                begin errors++; $display("FAIL replicate_window got %b %h want 1 0303030313", m_valid, m_col); end
            end
        end
    endtask

    task automatic test_overflow();
        int max_x = 0;
        stim.delete();
        for (int l = 0; l < 4; l++) add_line(l, D, 0, l == 0, 1);
        add_line(4, D + 2, 0, 0, 1);
        add_line(5, 5, 0, 0, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid || ovf !== md_ovf)
            begin errors++; $display("FAIL ovf_flags idx %0d got v%b o%b want v%b o%b", i, m_valid, ovf, exp_valid, md_ovf); end
            if (exp_valid) begin
                checks++;
                if (m_col !== exp_col || m_x !== AW'(exp_x) || m_sol !== exp_sol)
                begin errors++; $display("FAIL ovf_col idx %0d got %h/%0d want %h/%0d", i, m_col, m_x, exp_col, exp_x); end
            end
            if (m_valid && int'(m_x) > max_x) max_x = int'(m_x);
        end
        checks++; if (max_x != D - 1) begin errors++; $display("FAIL ovf_max_x got %0d want %0d", max_x, D - 1); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    endtask

    task automatic test_sof_midline();
        px_t p;
        stim.delete();
        for (int l = 0; l < 5; l++) add_line(l, 8, 0, l == 0, 0);
        for (int x = 0; x < 8; x++) begin
            p.v = 1'b1; p.sol = (x == 0) || (x == 3); p.sof = (x == 3);
            p.d = W'(8'h50 + x);
            stim.push_back(p);
        end
        for (int l = 1; l < 6; l++) add_line(l + 8, 5, 0, 0, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL sof_valid idx %0d got %b want %b", i, m_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (m_col !== exp_col || m_x !== AW'(exp_x) || m_sol !== exp_sol)
                begin errors++; $display("FAIL sof_col idx %0d got %h/%0d want %h/%0d", i, m_col, m_x, exp_col, exp_x); end
            end
        end
    endtask

    task automatic test_reset_midline();
        stim.delete();
        for (int l = 0; l < 4; l++) add_line(l, 8, 0, l == 0, 1);
        add_line(4, 4, 0, 0, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL pre_rst_valid idx %0d got %b want %b", i, m_valid, exp_valid); end
        end
        #2 rst_n = 1'b0;
        #1;
        md_act = 1'b0; md_ovf = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_col !== '0 || m_x !== '0 || m_sol !== 1'b0 || ovf !== 1'b0)
        begin errors++; $display("FAIL async_reset got %b %h %0d %b %b want all 0", m_valid, m_col, m_x, m_sol, ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        stim.delete();
        add_line(5, 8, 0, 0, 1);
        add_line(6, 8, 0, 0, 1);
        for (int l = 0; l < 6; l++) add_line(l, 8, 20, l == 0, 1);
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL post_rst_valid idx %0d got %b want %b", i, m_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (m_col !== exp_col || m_x !== AW'(exp_x))
                begin errors++; $display("FAIL post_rst_col idx %0d got %h/%0d want %h/%0d", i, m_col, m_x, exp_col, exp_x); end
            end
        end
    endtask

    task automatic test_gaps();
        logic [5*W-1:0] q1[$];
        logic [5*W-1:0] q2[$];
        px_t idle;
        idle = '0;
        stim.delete();
        for (int l = 0; l < 7; l++) add_line(l, 10, 0, l == 0, 1);
        stim2.delete();
        foreach (stim[i]) begin
            if ($urandom_range(1) == 1) stim2.push_back(idle);
            stim2.push_back(stim[i]);
        end
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid || (exp_valid && m_col !== exp_col))
            begin errors++; $display("FAIL nogap_col idx %0d got %b %h want %b %h", i, m_valid, m_col, exp_valid, exp_col); end
            if (m_valid) q1.push_back(m_col);
        end
        foreach (stim2[i]) begin
            step(stim2[i]);
            checks++;
            if (m_valid !== exp_valid || (exp_valid && m_col !== exp_col))
            begin errors++; $display("FAIL gap_col idx %0d got %b %h want %b %h", i, m_valid, m_col, exp_valid, exp_col); end
            if (m_valid) q2.push_back(m_col);
        end
        checks++;
        if (q1.size() != q2.size() || q1.size() == 0)
        begin errors++; $display("FAIL gap_seq_len got %0d want %0d", q2.size(), q1.size()); end
        for (int i = 0; i < q1.size() && i < q2.size(); i++) begin
            checks++;
            if (q2[i] !== q1[i]) begin errors++; $display("FAIL gap_seq idx %0d got %h want %h", i, q2[i], q1[i]); end
        end
    endtask

    task automatic test_random();
        int len;
        int nl;
        stim.delete();
        for (int f = 0; f < 3; f++) begin
            len = $urandom_range(6, 14);
            nl  = $urandom_range(5, 9);
            for (int l = 0; l < nl; l++) begin
                add_line(l, len, 30, l == 0, 1);
                if ($urandom_range(1) == 1 && len > 2) len--;
            end
        end
        foreach (stim[i]) begin
            step(stim[i]);
            checks++;
            if (m_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid idx %0d got %b want %b", i, m_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if (m_col !== exp_col || m_x !== AW'(exp_x) || m_sol !== exp_sol)
                begin errors++; $display("FAIL rnd_col idx %0d got %h/%0d/%b want %h/%0d/%b", i, m_col, m_x, m_sol, exp_col, exp_x, exp_sol); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_sol = 1'b0; s_sof = 1'b0; s_data = '0;
        md_act = 1'b0; md_line = 0; md_x = 0; md_ovf = 1'b0;
        exp_valid = 1'b0; exp_col = '0; exp_x = 0; exp_sol = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_frame();
        test_overflow();
        test_sof_midline();
        test_reset_midline();
        test_gaps();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
